hazard_unit: RTL and testbench

Execute-stage hazard controller for the 5-stage pipeline. It produces the 2-bit select codes for the EX-stage operand forwarding muxes (00 = register file, 01 = writeback result, 10 = memory-stage ALU result). It also generates per-stage stall and flush controls for load-use and branch hazards, and runs the data-memory request/acknowledge handshake that freezes the pipeline while a memory access is outstanding. Forward selects are computed in Decode and registered into Execute, which takes the comparators off the EX critical path.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_unit_fwd_sel.sv | 23 ++
 rtl/hazard_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the execute-stage hazard controller: forwarding
// select encodings, memory handshake states and the register-match helper.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_t;

    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Per-operand forwarding comparator evaluated in Decode; the Execute-stage
// producer is younger than the Memory-stage one and therefore takes priority.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_e,
    input  logic       reg_write_m,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_e && reg_match(rd_e, rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_m && reg_match(rd_m, rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Execute-stage hazard controller: registered forwarding selects, load-use and
// branch stall/flush generation, data-memory handshake and a stall counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic [4:0]           rs1_e,
    input  logic [4:0]           rs2_e,
    input  logic [4:0]           rd_e,
    input  logic [4:0]           rd_m,
    input  logic                 reg_write_e,
    input  logic                 reg_write_m,
    input  logic                 mem_read_e,
    input  logic                 pc_src_e,
    input  logic                 mem_access_m,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic [1:0]           forward_a_e,
    output logic [1:0]           forward_b_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 stall_m,
    output logic                 stall_w,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    mem_state_t state;
    mem_state_t state_next;

    logic [1:0] fwd_a_d;
    logic [1:0] fwd_b_d;
    logic       lwstall;
    logic       memstall;
    logic       any_stall;
    logic       unused_e_srcs;

    // Execute-stage sources are not needed: selects are resolved one stage early.
    assign unused_e_srcs = ^{rs1_e, rs2_e};

    fwd_sel u_fwd_a (
        .rs          (rs1_d),
        .rd_e        (rd_e),
        .rd_m        (rd_m),
        .reg_write_e (reg_write_e),
        .reg_write_m (reg_write_m),
        .sel         (fwd_a_d)
    );

    fwd_sel u_fwd_b (
        .rs          (rs2_d),
        .rd_e        (rd_e),
        .rd_m        (rd_m),
        .reg_write_e (reg_write_e),
        .reg_write_m (reg_write_m),
        .sel         (fwd_b_d)
    );

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        stall_w    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;

        memstall = mem_access_m & ~mem_ack;
        lwstall  = mem_read_e & (reg_match(rd_e, rs1_d) | reg_match(rd_e, rs2_d));

        case (state)
            MEM_IDLE: begin
                if (mem_access_m) begin
                    mem_req = 1'b1;
                    if (!mem_ack) begin
                        state_next = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_next = MEM_IDLE;
                end
            end
            default: state_next = MEM_IDLE;
        endcase

        // A pending memory access freezes everything, so a branch or load-use
        // held in place re-raises its flush/stall once the access releases.
        if (memstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            stall_w = 1'b1;
        end else begin
            stall_f = lwstall;
            stall_d = lwstall;
            flush_d = pc_src_e;
            flush_e = pc_src_e | lwstall;
        end

        if (reset) begin
            mem_req = 1'b0;
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            stall_m = 1'b0;
            stall_w = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
        end
    end

    assign any_stall = stall_f | stall_d | stall_e | stall_m | stall_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= MEM_IDLE;
            forward_a_e  <= FWD_RF;
            forward_b_e  <= FWD_RF;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            if (flush_e) begin
                forward_a_e <= FWD_RF;
                forward_b_e <= FWD_RF;
            end else if (!stall_e) begin
                forward_a_e <= fwd_a_d;
                forward_b_e <= fwd_b_d;
            end
            if (any_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed checks of hazard_unit against a behavioural model
// of the hazard rules; a CNT_WIDTH=4 copy exercises counter saturation.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m;
    logic       reg_write_e, reg_write_m, mem_read_e, pc_src_e, mem_access_m, mem_ack;

    logic        mem_req, stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [31:0] stall_cycles;

    logic        s_mem_req, s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_stall_w, s_flush_d, s_flush_e;
    logic [1:0]  s_forward_a_e, s_forward_b_e;
    logic [3:0]  s_stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [1:0]  m_fa, m_fb;
    logic [31:0] m_cnt;
    int          m_cnt_small;
    bit          m_waiting;

    always #5 clk = ~clk;

    hazard_unit u_dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
        .mem_read_e(mem_read_e), .pc_src_e(pc_src_e),
        .mem_access_m(mem_access_m), .mem_ack(mem_ack), .mem_req(mem_req),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
        .flush_d(flush_d), .flush_e(flush_e), .stall_cycles(stall_cycles)
    );

    hazard_unit #(.CNT_WIDTH(4)) u_dut_small (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
        .mem_read_e(mem_read_e), .pc_src_e(pc_src_e),
        .mem_access_m(mem_access_m), .mem_ack(mem_ack), .mem_req(s_mem_req),
        .forward_a_e(s_forward_a_e), .forward_b_e(s_forward_b_e),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m), .stall_w(s_stall_w),
        .flush_d(s_flush_d), .flush_e(s_flush_e), .stall_cycles(s_stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (reg_write_e && rd_e != 5'd0 && rd_e == rs) return 2'b10;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        reset = 1'b0;
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0;
        reg_write_e = 1'b0; reg_write_m = 1'b0; mem_read_e = 1'b0;
        pc_src_e = 1'b0; mem_access_m = 1'b0; mem_ack = 1'b0;
    endtask

    // Check one cycle against the model, then advance the model over the edge.
    task automatic step();
        bit ms, lw, sf, se, fd, fe, rq;
        logic [7:0] exp_ctl;
        ms = !reset && mem_access_m && !mem_ack;
        lw = !reset && !ms && mem_read_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
        sf = ms || lw;
        se = ms;
        fd = !reset && !ms && pc_src_e;
        fe = fd || lw;
        rq = !reset && !m_waiting && mem_access_m;
        exp_ctl = {rq, sf, sf, se, se, se, fd, fe};
        #1;
        check("ctl", {24'd0, mem_req, stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e}, {24'd0, exp_ctl});
        check("ctl_small", {24'd0, s_mem_req, s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_stall_w, s_flush_d, s_flush_e}, {24'd0, exp_ctl});
        check("fwd", {28'd0, forward_a_e, forward_b_e}, {28'd0, m_fa, m_fb});
        check("fwd_small", {28'd0, s_forward_a_e, s_forward_b_e}, {28'd0, m_fa, m_fb});
        check("stall_cycles", stall_cycles, m_cnt);
        check("stall_cycles_small", {28'd0, s_stall_cycles}, m_cnt_small);
        @(posedge clk);
        if (reset) begin
            m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0; m_cnt_small = 0; m_waiting = 0;
        end else begin
            if (fe) begin
                m_fa = 2'b00; m_fb = 2'b00;
            end else if (!se) begin
                m_fa = ref_fwd(rs1_d); m_fb = ref_fwd(rs2_d);
            end
            if (sf || se) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_cnt_small < 15) m_cnt_small = m_cnt_small + 1;
            end
            if (!m_waiting && mem_access_m && !mem_ack) m_waiting = 1;
            else if (m_waiting && mem_ack) m_waiting = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0; m_cnt_small = 0; m_waiting = 0;
        clear_inputs();
        @(negedge clk);

        // Reset dominates active hazard inputs.
        reset = 1'b1; mem_access_m = 1'b1; pc_src_e = 1'b1; mem_read_e = 1'b1;
        rd_e = 5'd3; rs1_d = 5'd3;
        step();
        step();
        #1 check("reset_fwd_a", {30'd0, forward_a_e}, 32'd0);
        check("reset_cnt", stall_cycles, 32'd0);
        do_reset();

        // Forwarding from Execute, Memory, and x0.
        reg_write_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
        step();
        #1 check("fwd_ex", {30'd0, forward_a_e}, 32'd2);
        clear_inputs(); reg_write_m = 1'b1; rd_m = 5'd5; rs1_d = 5'd5;
        step();
        #1 check("fwd_mem", {30'd0, forward_a_e}, 32'd1);
        clear_inputs(); reg_write_e = 1'b1; reg_write_m = 1'b1; rs1_d = 5'd0;
        step();
        #1 check("fwd_x0", {30'd0, forward_a_e}, 32'd0);

        // Load-use: stall one cycle, then forward from writeback.
        clear_inputs(); mem_read_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        #1 check("lw_stall", {29'd0, stall_f, stall_d, flush_e}, 32'd7);
        step();
        clear_inputs(); reg_write_m = 1'b1; rd_m = 5'd7; rs2_d = 5'd7;
        step();
        #1 check("lw_fwd_b", {30'd0, forward_b_e}, 32'd1);

        // Three-cycle memory wait with forward select held.
        do_reset();
        reg_write_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9;
        step();
        clear_inputs(); mem_access_m = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #1 check("mem_hold_fwd", {30'd0, forward_a_e}, 32'd2);
        mem_ack = 1'b1;
        step();
        clear_inputs();
        #1 check("mem_cnt3", stall_cycles, 32'd3);

        // Branch during memstall flushes only on the release cycle.
        do_reset();
        mem_access_m = 1'b1; pc_src_e = 1'b1;
        step();
        step();
        mem_ack = 1'b1;
        #1 check("branch_release", {30'd0, flush_d, flush_e}, 32'd3);
        step();

        // Reset while waiting, then a stray ack is ignored.
        do_reset();
        mem_access_m = 1'b1;
        step();
        reset = 1'b1;
        step();
        clear_inputs(); mem_ack = 1'b1;
        #1 check("stray_ack_req", {31'd0, mem_req}, 32'd0);
        step();
        clear_inputs(); mem_access_m = 1'b1;
        #1 check("req_after_reset", {31'd0, mem_req}, 32'd1);
        step();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            reset        = ($urandom_range(0, 99) < 2);
            rs1_d        = 5'($urandom_range(0, 7));
            rs2_d        = 5'($urandom_range(0, 7));
            rs1_e        = 5'($urandom_range(0, 31));
            rs2_e        = 5'($urandom_range(0, 31));
            rd_e         = 5'($urandom_range(0, 7));
            rd_m         = 5'($urandom_range(0, 7));
            reg_write_e  = ($urandom_range(0, 99) < 60);
            reg_write_m  = ($urandom_range(0, 99) < 60);
            mem_read_e   = ($urandom_range(0, 99) < 30);
            pc_src_e     = ($urandom_range(0, 99) < 15);
            mem_access_m = ($urandom_range(0, 99) < 35);
            mem_ack      = ($urandom_range(0, 99) < 40);
            step();
        end

        // Saturation of the narrow counter.
        do_reset();
        mem_access_m = 1'b1;
        for (int i = 0; i < 20; i++) step();
        clear_inputs();
        #1 check("sat_small", {28'd0, s_stall_cycles}, 32'd15);
        check("sat_wide", stall_cycles, 32'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
